// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier with a start/busy/done handshake.
// Optional macro SHIFT_ADD_MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
module shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             Busy,
    output logic             Done,
    output logic [2*N-1:0]   Product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2*N-1:0]   mcand_q;
    logic [2*N-1:0]   acc_q;
    logic [2*N-1:0]   acc_d;
    logic [2*N-1:0]   product_q;
    logic [N-1:0]     mplier_q;
    logic [N-1:0]     mplier_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             last_d;

    // Per-cycle partial-product add and the CALC exit condition.
    always_comb begin
        acc_d    = acc_q;
        mplier_d = mplier_q >> 1;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        last_d = (cnt_q == LAST_CNT) || (mplier_d == {N{1'b0}});
`else
        last_d = (cnt_q == LAST_CNT);
`endif
    end

    // Control FSM and datapath registers; reset has priority over Start.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            mcand_q   <= {(2*N){1'b0}};
            mplier_q  <= {N{1'b0}};
            acc_q     <= {(2*N){1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*N){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        mcand_q  <= {{N{1'b0}}, A};
                        mplier_q <= B;
                        acc_q    <= {(2*N){1'b0}};
                        cnt_q    <= {CW{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (last_d) begin
                        product_q <= acc_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: the driver queues expected results,
// a negedge monitor pops and checks product, latency, busy length and handshake rules.
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic           Start = 1'b0;
    logic [N-1:0]   A = '0;
    logic [N-1:0]   B = '0;
    logic           Busy;
    logic           Done;
    logic [2*N-1:0] Product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2*N-1:0] prod;
        int             calc;
        int             acc;
    } exp_t;

    exp_t q[$];

    shift_add_multiplier #(.N(N)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Product(Product)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int calc_cycles(input logic [N-1:0] b);
        int c;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        c = 1;
        for (int i = 0; i < N; i++) if (b[i]) c = i + 1;
`else
        c = N;
`endif
        return c;
    endfunction

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) if (b[i]) p = p + ({{N{1'b0}}, a} << i);
        return p;
    endfunction

    task automatic push(input logic [2*N-1:0] p, input logic [N-1:0] b);
        exp_t e;
        e.prod = p;
        e.calc = calc_cycles(b);
        e.acc  = cyc;
        q.push_back(e);
    endtask

    // Drive one Start pulse once the DUT is not busy; the accept edge lies between the two negedges.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] p);
        int w;
        w = 0;
        @(negedge Clk);
        while (Busy && w < 100) begin
            @(negedge Clk);
            w++;
        end
        if (Busy) check("wait_idle_timeout", 1, 0);
        Start = 1'b1;
        A = a;
        B = b;
        @(negedge Clk);
        Start = 1'b0;
        push(p, b);
    endtask

    // Monitor: pops the scoreboard on Done and checks the handshake every cycle.
    int busy_cnt = 0;
    logic [2*N-1:0] last_prod = '0;
    always @(negedge Clk) begin
        exp_t e;
        #1;
        if (!Rst) begin
            check("busy_done_exclusive", longint'(Busy && Done), 0);
            if (Busy) busy_cnt++;
            if (Done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("product", Product, e.prod);
                    check("latency", cyc - e.acc, e.calc);
                    check("busy_cycles", busy_cnt, e.calc);
                end
                busy_cnt  = 0;
                last_prod = Product;
            end else begin
                check("product_hold", Product, last_prod);
            end
        end else begin
            busy_cnt  = 0;
            last_prod = '0;
        end
    end

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs[10] = '{
        '{8'd13,  8'd11,  16'd143},
        '{8'd255, 8'd255, 16'hFE01},
        '{8'd0,   8'd200, 16'd0},
        '{8'd5,   8'd1,   16'd5},
        '{8'd5,   8'd128, 16'd640},
        '{8'd1,   8'd1,   16'd1},
        '{8'd255, 8'd0,   16'd0},
        '{8'd128, 8'd2,   16'd256},
        '{8'd170, 8'd85,  16'd14450},
        '{8'd200, 8'd3,   16'd600}
    };

    initial begin
        int w;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        repeat (2) @(negedge Clk);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_product", Product, 0);
        Rst = 1'b0;

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].p);

        // Start pulses with other operands during CALC must be ignored.
        issue(8'd77, 8'd200, 16'd15400);
        Start = 1'b1; A = 8'd1; B = 8'd1;
        @(negedge Clk);
        Start = 1'b0; A = 8'd99; B = 8'd99;
        @(negedge Clk);
        Start = 1'b1; A = 8'd2; B = 8'd2;
        @(negedge Clk);
        Start = 1'b0;

        // Back-to-back: Start held, new operands presented in the DONE cycle.
        @(negedge Clk);
        w = 0;
        while (Busy && w < 100) begin @(negedge Clk); w++; end
        Start = 1'b1; A = 8'd3; B = 8'd4;
        @(negedge Clk);
        push(16'd12, 8'd4);
        w = 0;
        while (!Done && w < 50) begin @(negedge Clk); w++; end
        if (!Done) check("b2b_done_timeout", 1, 0);
        A = 8'd7; B = 8'd9;
        @(negedge Clk);
        push(16'd63, 8'd9);
        Start = 1'b0;

        // Reset in the 4th CALC cycle discards the in-flight result.
        issue(8'd100, 8'd100, 16'd10000);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        Start = 1'b1;
        q.delete();
        @(negedge Clk);
        check("midreset_busy", Busy, 0);
        check("midreset_done", Done, 0);
        check("midreset_product", Product, 0);
        Rst = 1'b0;
        Start = 1'b0;
        repeat (12) @(negedge Clk);
        issue(8'd100, 8'd100, 16'd10000);

        for (int i = 0; i < 150; i++) begin
            ra = N'($urandom_range(0, 255));
            rb = N'($urandom_range(0, 255));
            issue(ra, rb, model(ra, rb));
        end

        w = 0;
        while (q.size() != 0 && w < 200) begin @(negedge Clk); w++; end
        check("missing_done", q.size(), 0);
        repeat (2) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
